mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port, fixed-latency unified memory between the instruction
// fetch port (I) and the load/store port (D). One requester is granted at a
// time. The access is held on the mem_* bus for exactly LATENCY cycles. The
// result is returned with a one-cycle ready pulse on the granted port.
//
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//   defined     : simultaneous requests alternate, based on the last grant
//   not defined : fixed D-port priority
//
// Parameters
//   LATENCY  memory access cycles (mem_valid high time), 1..15
//   AW       address width
//   DW       data width
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   i_req      fetch request, held until i_ready or i_kill
//   i_addr     fetch address
//   i_kill     IF flush; cancels delivery of the fetch in flight
//   i_ready    one-cycle pulse, i_rdata valid
//   i_rdata    fetched instruction (registered)
//   i_stall    fetch port stall to pipeline control
//   d_req      data request, held until d_ready
//   d_we       1 = store, 0 = load
//   d_addr     data address
//   d_wdata    store data
//   d_ready    one-cycle pulse, access complete (d_rdata valid for loads)
//   d_rdata    load data (registered)
//   d_stall    data port stall to pipeline control
//   mem_valid  memory access in progress
//   mem_we     write strobe
//   mem_addr   latched access address
//   mem_wdata  latched store data
//   mem_rdata  memory read data, valid in the last access cycle
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic          i_kill,
    output logic          i_ready,
    output logic [DW-1:0] i_rdata,
    output logic          i_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ready,
    output logic [DW-1:0] d_rdata,
    output logic          d_stall,
    output logic          mem_valid,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    // The counter is loaded with LATENCY-1 so that the access ends on cnt==0.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic          killed_q;
    logic          iReady_q;
    logic          dReady_q;
    logic [DW-1:0] iRdata_q;
    logic [DW-1:0] dRdata_q;
    logic          memValid_q;
    logic          memWe_q;
    logic [AW-1:0] memAddr_q;
    logic [DW-1:0] memWdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic          lastGrantD_q;
`endif

    logic iCand;
    logic dCand;
    logic grantI;
    logic grantD;

    // A port whose ready pulse is out this cycle is still holding its old
    // request, so it is masked to avoid granting that request a second time.
    // A killed fetch is never granted.
    always_comb begin
        iCand  = i_req & ~iReady_q & ~i_kill;
        dCand  = d_req & ~dReady_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        grantD = dCand & (~iCand | ~lastGrantD_q);
`else
        grantD = dCand;
`endif
        grantI = iCand & ~grantD;
    end

    // Arbitration FSM. All outputs toward the memory and the ready/rdata
    // outputs are registered here. The ready flags default to 0 so that they
    // only pulse for one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            killed_q     <= 1'b0;
            iReady_q     <= 1'b0;
            dReady_q     <= 1'b0;
            iRdata_q     <= '0;
            dRdata_q     <= '0;
            memValid_q   <= 1'b0;
            memWe_q      <= 1'b0;
            memAddr_q    <= '0;
            memWdata_q   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            lastGrantD_q <= 1'b1;
`endif
        end else begin
            iReady_q <= 1'b0;
            dReady_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grantD) begin
                        state_q      <= BUSY_D;
                        cnt_q        <= CNT_LOAD;
                        memValid_q   <= 1'b1;
                        memWe_q      <= d_we;
                        memAddr_q    <= d_addr;
                        memWdata_q   <= d_wdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        lastGrantD_q <= 1'b1;
`endif
                    end else if (grantI) begin
                        state_q      <= BUSY_I;
                        cnt_q        <= CNT_LOAD;
                        killed_q     <= 1'b0;
                        memValid_q   <= 1'b1;
                        memWe_q      <= 1'b0;
                        memAddr_q    <= i_addr;
                        memWdata_q   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        lastGrantD_q <= 1'b0;
`endif
                    end
                end
                BUSY_I: begin
                    // A flush during the fetch lets the memory access finish
                    // but suppresses delivery to the pipeline.
                    if (i_kill) begin
                        killed_q <= 1'b1;
                    end
                    if (cnt_q == 4'd0) begin
                        state_q    <= IDLE;
                        memValid_q <= 1'b0;
                        iRdata_q   <= mem_rdata;
                        iReady_q   <= ~(killed_q | i_kill);
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                BUSY_D: begin
                    if (cnt_q == 4'd0) begin
                        state_q    <= IDLE;
                        memValid_q <= 1'b0;
                        dRdata_q   <= mem_rdata;
                        dReady_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    memValid_q <= 1'b0;
                end
            endcase
        end
    end

    // A kill arriving in the ready cycle itself still cancels delivery.
    // Stalls are gated by reset so that every output reads 0 while reset is held.
    assign i_ready   = iReady_q & ~i_kill;
    assign d_ready   = dReady_q;
    assign i_rdata   = iRdata_q;
    assign d_rdata   = dRdata_q;
    assign i_stall   = reset & i_req & ~i_ready & ~i_kill;
    assign d_stall   = reset & d_req & ~d_ready;
    assign mem_valid = memValid_q;
    assign mem_we    = memWe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed testbench for mem_port_arbiter. The main instance uses LATENCY=4.
// A second instance uses LATENCY=1. Most single-cycle behaviour comes from a
// vector table. Kill, reset-in-flight and LATENCY=1 sequences are written
// out by hand.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    logic        iReq, iKill, dReq, dWe;
    logic [31:0] iAddr, dAddr, dWdata, memRdata;
    logic        iReady, iStall, dReady, dStall, memValid, memWe;
    logic [31:0] iRdata, dRdata, memAddr, memWdata;

    logic        l1IReq, l1IKill, l1DReq, l1DWe;
    logic [31:0] l1IAddr, l1DAddr, l1DWdata, l1MemRdata;
    logic        l1IReady, l1IStall, l1DReady, l1DStall, l1MemValid, l1MemWe;
    logic [31:0] l1IRdata, l1DRdata, l1MemAddr, l1MemWdata;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.LATENCY(4), .AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .i_req(iReq), .i_addr(iAddr), .i_kill(iKill),
        .i_ready(iReady), .i_rdata(iRdata), .i_stall(iStall),
        .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata),
        .d_ready(dReady), .d_rdata(dRdata), .d_stall(dStall),
        .mem_valid(memValid), .mem_we(memWe), .mem_addr(memAddr),
        .mem_wdata(memWdata), .mem_rdata(memRdata)
    );

    mem_port_arbiter #(.LATENCY(1), .AW(32), .DW(32)) dutL1 (
        .clk(clk), .reset(reset),
        .i_req(l1IReq), .i_addr(l1IAddr), .i_kill(l1IKill),
        .i_ready(l1IReady), .i_rdata(l1IRdata), .i_stall(l1IStall),
        .d_req(l1DReq), .d_we(l1DWe), .d_addr(l1DAddr), .d_wdata(l1DWdata),
        .d_ready(l1DReady), .d_rdata(l1DRdata), .d_stall(l1DStall),
        .mem_valid(l1MemValid), .mem_we(l1MemWe), .mem_addr(l1MemAddr),
        .mem_wdata(l1MemWdata), .mem_rdata(l1MemRdata)
    );

    // One table row = one clock cycle of stimulus and the expected outputs.
    // ex bits: {iReady, iStall, dReady, dStall, memValid, memWe}.
    typedef struct {
        logic        iReq;
        logic        iKill;
        logic        dReq;
        logic        dWe;
        logic [31:0] iAddr;
        logic [31:0] dAddr;
        logic [31:0] dWdata;
        logic [31:0] memRdata;
        logic [5:0]  ex;
        logic [31:0] expMemAddr;
        logic [31:0] expMemWdata;
        logic        chkIRd;
        logic [31:0] expIRdata;
        logic        chkDRd;
        logic [31:0] expDRdata;
    } vec_t;

    vec_t vecs[$];
    vec_t cur;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clearCur();
        cur.iReq     = 1'b0;
        cur.iKill    = 1'b0;
        cur.dReq     = 1'b0;
        cur.dWe      = 1'b0;
        cur.iAddr    = 32'h0;
        cur.dAddr    = 32'h0;
        cur.dWdata   = 32'h0;
        cur.memRdata = 32'h0;
        cur.chkIRd   = 1'b0;
        cur.expIRdata = 32'h0;
        cur.chkDRd   = 1'b0;
        cur.expDRdata = 32'h0;
    endtask

    task automatic addRow(input logic [5:0] ex, input logic [31:0] ema,
                          input logic [31:0] emwd, input int n);
        for (int k = 0; k < n; k++) begin
            cur.ex          = ex;
            cur.expMemAddr  = ema;
            cur.expMemWdata = emwd;
            vecs.push_back(cur);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        iReq     = v.iReq;
        iKill    = v.iKill;
        dReq     = v.dReq;
        dWe      = v.dWe;
        iAddr    = v.iAddr;
        dAddr    = v.dAddr;
        dWdata   = v.dWdata;
        memRdata = v.memRdata;
    endtask

    task automatic checkVector(input int idx, input vec_t v);
        checkBit($sformatf("row%0d i_ready", idx), iReady, v.ex[5]);
        checkBit($sformatf("row%0d i_stall", idx), iStall, v.ex[4]);
        checkBit($sformatf("row%0d d_ready", idx), dReady, v.ex[3]);
        checkBit($sformatf("row%0d d_stall", idx), dStall, v.ex[2]);
        checkBit($sformatf("row%0d mem_valid", idx), memValid, v.ex[1]);
        if (v.ex[1]) begin
            checkBit($sformatf("row%0d mem_we", idx), memWe, v.ex[0]);
            checkOutput($sformatf("row%0d mem_addr", idx), memAddr, v.expMemAddr);
            if (v.ex[0])
                checkOutput($sformatf("row%0d mem_wdata", idx), memWdata, v.expMemWdata);
        end
        if (v.chkIRd)
            checkOutput($sformatf("row%0d i_rdata", idx), iRdata, v.expIRdata);
        if (v.chkDRd)
            checkOutput($sformatf("row%0d d_rdata", idx), dRdata, v.expDRdata);
    endtask

    initial begin
        reset = 1'b0;
        iReq = 1'b0; iKill = 1'b0; dReq = 1'b0; dWe = 1'b0;
        iAddr = 32'h0; dAddr = 32'h0; dWdata = 32'h0; memRdata = 32'h0;
        l1IReq = 1'b0; l1IKill = 1'b0; l1DReq = 1'b0; l1DWe = 1'b0;
        l1IAddr = 32'h0; l1DAddr = 32'h0; l1DWdata = 32'h0; l1MemRdata = 32'h0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #2;
        checkBit("reset mem_valid", memValid, 1'b0);
        checkBit("reset i_ready", iReady, 1'b0);
        checkBit("reset d_ready", dReady, 1'b0);
        checkOutput("reset mem_addr", memAddr, 32'h0);
        checkOutput("reset i_rdata", iRdata, 32'h0);
        checkOutput("reset d_rdata", dRdata, 32'h0);
        checkBit("reset L1 mem_valid", l1MemValid, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // ---------------- vector table ----------------
        // Fetch at 0x100, LATENCY=4: grant in row 2, data back in row 7.
        clearCur();
        addRow(6'b000000, 32'h0, 32'h0, 2);
        cur.iReq = 1'b1; cur.iAddr = 32'h100; cur.memRdata = 32'h00500093;
        addRow(6'b010000, 32'h0, 32'h0, 1);
        addRow(6'b010010, 32'h100, 32'h0, 4);
        cur.chkIRd = 1'b1; cur.expIRdata = 32'h00500093;
        addRow(6'b100000, 32'h0, 32'h0, 1);
        cur.iReq = 1'b0;
        addRow(6'b000000, 32'h0, 32'h0, 1);
        // A fetch with i_kill high in IDLE is not granted and does not stall.
        clearCur();
        cur.iReq = 1'b1; cur.iKill = 1'b1; cur.iAddr = 32'h180;
        addRow(6'b000000, 32'h0, 32'h0, 1);
        clearCur();
        addRow(6'b000000, 32'h0, 32'h0, 1);
        // A load at 0x40 where d_req is still held in the d_ready cycle.
        // No second access may follow.
        cur.dReq = 1'b1; cur.dAddr = 32'h40; cur.memRdata = 32'h12345678;
        addRow(6'b000100, 32'h0, 32'h0, 1);
        addRow(6'b000110, 32'h40, 32'h0, 4);
        cur.chkDRd = 1'b1; cur.expDRdata = 32'h12345678;
        addRow(6'b001000, 32'h0, 32'h0, 1);
        cur.dReq = 1'b0;
        addRow(6'b000000, 32'h0, 32'h0, 2);
        // Simultaneous fetch at 0x300 and store of DEADBEEF at 0x2000.
        // The last grant so far was D.
        clearCur();
        cur.iReq = 1'b1; cur.iAddr = 32'h300;
        cur.dReq = 1'b1; cur.dWe = 1'b1; cur.dAddr = 32'h2000; cur.dWdata = 32'hDEADBEEF;
        cur.memRdata = 32'hCAFE0001;
        addRow(6'b010100, 32'h0, 32'h0, 1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        addRow(6'b010110, 32'h300, 32'h0, 4);
        cur.chkIRd = 1'b1; cur.expIRdata = 32'hCAFE0001;
        addRow(6'b100100, 32'h0, 32'h0, 1);
        cur.iReq = 1'b0; cur.chkIRd = 1'b0;
        addRow(6'b000111, 32'h2000, 32'hDEADBEEF, 4);
        addRow(6'b001000, 32'h0, 32'h0, 1);
`else
        addRow(6'b010111, 32'h2000, 32'hDEADBEEF, 4);
        addRow(6'b011000, 32'h0, 32'h0, 1);
        cur.dReq = 1'b0;
        addRow(6'b010010, 32'h300, 32'h0, 4);
        cur.chkIRd = 1'b1; cur.expIRdata = 32'hCAFE0001;
        addRow(6'b100000, 32'h0, 32'h0, 1);
`endif
        clearCur();
        addRow(6'b000000, 32'h0, 32'h0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkVector(i, vecs[i]);
            tick();
        end

        // ---------------- i_kill in the 2nd BUSY_I cycle ----------------
        iReq = 1'b1; iAddr = 32'h400; memRdata = 32'h0BAD0000;
        #1;
        checkBit("kill grant i_stall", iStall, 1'b1);
        tick();
        checkBit("kill busy1 mem_valid", memValid, 1'b1);
        checkOutput("kill busy1 mem_addr", memAddr, 32'h400);
        tick();
        iKill = 1'b1;
        #1;
        checkBit("kill busy2 mem_valid", memValid, 1'b1);
        checkBit("kill busy2 i_stall", iStall, 1'b0);
        tick();
        iKill = 1'b0; iAddr = 32'h500;
        #1;
        checkBit("kill busy3 mem_valid", memValid, 1'b1);
        checkBit("kill busy3 i_stall", iStall, 1'b1);
        tick();
        checkBit("kill busy4 mem_valid", memValid, 1'b1);
        checkBit("kill busy4 i_ready", iReady, 1'b0);
        tick();
        checkBit("kill done mem_valid", memValid, 1'b0);
        checkBit("kill done i_ready", iReady, 1'b0);
        checkOutput("kill done i_rdata", iRdata, 32'h0BAD0000);
        checkBit("kill done i_stall", iStall, 1'b1);
        tick();
        memRdata = 32'h11110000;
        #1;
        checkBit("refetch mem_valid", memValid, 1'b1);
        checkOutput("refetch mem_addr", memAddr, 32'h500);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkBit($sformatf("refetch busy%0d mem_valid", k + 2), memValid, 1'b1);
            checkBit($sformatf("refetch busy%0d i_ready", k + 2), iReady, 1'b0);
        end
        tick();
        checkBit("refetch i_ready", iReady, 1'b1);
        checkOutput("refetch i_rdata", iRdata, 32'h11110000);
        iReq = 1'b0;
        tick();
        checkBit("refetch pulse end", iReady, 1'b0);

        // ---------------- reset in the 2nd BUSY_D cycle ----------------
        dReq = 1'b1; dWe = 1'b0; dAddr = 32'h600; memRdata = 32'h600D600D;
        #1;
        checkBit("rst grant d_stall", dStall, 1'b1);
        tick();
        checkBit("rst busy1 mem_valid", memValid, 1'b1);
        tick();
        checkBit("rst busy2 mem_valid", memValid, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        checkBit("rst async mem_valid", memValid, 1'b0);
        checkBit("rst async d_ready", dReady, 1'b0);
        checkBit("rst async d_stall", dStall, 1'b0);
        #2;
        reset = 1'b1;
        tick();
        checkBit("rst regrant mem_valid", memValid, 1'b1);
        checkOutput("rst regrant mem_addr", memAddr, 32'h600);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkBit($sformatf("rst busy%0d mem_valid", k + 2), memValid, 1'b1);
            checkBit($sformatf("rst busy%0d d_stall", k + 2), dStall, 1'b1);
        end
        tick();
        checkBit("rst d_ready", dReady, 1'b1);
        checkOutput("rst d_rdata", dRdata, 32'h600D600D);
        dReq = 1'b0;
        tick();
        checkBit("rst idle mem_valid", memValid, 1'b0);

        // ---------------- LATENCY=1 back-to-back loads ----------------
        l1DReq = 1'b1; l1DAddr = 32'h10; l1MemRdata = 32'h000000A1;
        #1;
        checkBit("L1 grant d_stall", l1DStall, 1'b1);
        checkBit("L1 grant mem_valid", l1MemValid, 1'b0);
        tick();
        checkBit("L1 busy mem_valid", l1MemValid, 1'b1);
        checkOutput("L1 busy mem_addr", l1MemAddr, 32'h10);
        tick();
        checkBit("L1 d_ready", l1DReady, 1'b1);
        checkBit("L1 ready mem_valid", l1MemValid, 1'b0);
        checkOutput("L1 d_rdata", l1DRdata, 32'h000000A1);
        tick();
        l1DAddr = 32'h14; l1MemRdata = 32'h000000B2;
        #1;
        checkBit("L1 2nd grant mem_valid", l1MemValid, 1'b0);
        checkBit("L1 2nd grant d_ready", l1DReady, 1'b0);
        checkBit("L1 2nd grant d_stall", l1DStall, 1'b1);
        tick();
        checkBit("L1 2nd busy mem_valid", l1MemValid, 1'b1);
        checkOutput("L1 2nd busy mem_addr", l1MemAddr, 32'h14);
        tick();
        checkBit("L1 2nd d_ready", l1DReady, 1'b1);
        checkOutput("L1 2nd d_rdata", l1DRdata, 32'h000000B2);
        l1DReq = 1'b0;
        tick();
        checkBit("L1 idle mem_valid", l1MemValid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
